// File: rtl/amm_copy_sequencer_pkg.sv
// Shared types and helpers for the Avalon-MM memory-to-memory copy sequencer.
package amm_copy_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_LAUNCH,
    ST_STREAM,
    ST_DRAIN,
    ST_DONE
  } copy_state_t;

  // Byte length to word count; lsb = log2(bytes per word).
  function automatic logic [63:0] words_of(input logic [63:0] len, input int unsigned lsb);
    return len >> lsb;
  endfunction

  function automatic logic is_aligned(input logic [63:0] val, input int unsigned lsb);
    logic [63:0] mask;
    mask = (64'd1 << lsb) - 64'd1;
    return (val & mask) == 64'd0;
  endfunction

endpackage

// File: rtl/amm_copy_sequencer_if.sv
// Command port plus read/write master control and user-buffer signals of the copy sequencer.
interface amm_copy_sequencer_if #(
  parameter int ADDRESSWIDTH = 28,
  parameter int DATAWIDTH    = 32
);
  logic                    cmd_start;
  logic [ADDRESSWIDTH-1:0] cmd_src;
  logic [ADDRESSWIDTH-1:0] cmd_dst;
  logic [ADDRESSWIDTH-1:0] cmd_length;
  logic                    cmd_busy;
  logic                    cmd_done;
  logic                    cmd_error;
  logic [ADDRESSWIDTH-1:0] word_count;

  logic                    read_control_fixed_location;
  logic [ADDRESSWIDTH-1:0] read_control_read_base;
  logic [ADDRESSWIDTH-1:0] read_control_read_length;
  logic                    read_control_go;
  logic                    read_control_done;
  logic                    read_user_read_buffer;
  logic [DATAWIDTH-1:0]    read_user_buffer_output_data;
  logic                    read_user_data_available;

  logic                    write_control_fixed_location;
  logic [ADDRESSWIDTH-1:0] write_control_write_base;
  logic [ADDRESSWIDTH-1:0] write_control_write_length;
  logic                    write_control_go;
  logic                    write_control_done;
  logic                    write_user_write_buffer;
  logic [DATAWIDTH-1:0]    write_user_buffer_data;
  logic                    write_user_buffer_full;

  modport master (
    input  cmd_start, cmd_src, cmd_dst, cmd_length,
    output cmd_busy, cmd_done, cmd_error, word_count,
    output read_control_fixed_location, read_control_read_base, read_control_read_length,
    output read_control_go, read_user_read_buffer,
    input  read_control_done, read_user_buffer_output_data, read_user_data_available,
    output write_control_fixed_location, write_control_write_base, write_control_write_length,
    output write_control_go, write_user_write_buffer, write_user_buffer_data,
    input  write_control_done, write_user_buffer_full
  );

  modport slave (
    output cmd_start, cmd_src, cmd_dst, cmd_length,
    input  cmd_busy, cmd_done, cmd_error, word_count,
    input  read_control_fixed_location, read_control_read_base, read_control_read_length,
    input  read_control_go, read_user_read_buffer,
    output read_control_done, read_user_buffer_output_data, read_user_data_available,
    input  write_control_fixed_location, write_control_write_base, write_control_write_length,
    input  write_control_go, write_user_write_buffer, write_user_buffer_data,
    output write_control_done, write_user_buffer_full
  );
endinterface

// File: rtl/amm_copy_sequencer.sv
// Copies length bytes src->dst by launching both Avalon-MM masters and moving words buffer to buffer.
// Latency: go 2 cycles after start, 1 word/cycle streaming, done >=4 cycles after the last word.
// Backpressure: a word moves only when the read buffer has data and the write buffer is not full.
module amm_copy_sequencer
  import amm_copy_pkg::*;
#(
  parameter int ADDRESSWIDTH = 28,
  parameter int DATAWIDTH    = 32
) (
  input logic                clk,
  input logic                reset,
  amm_copy_sequencer_if.master bus
);

  localparam int BYTES = DATAWIDTH / 8;
  localparam int LSB   = $clog2(BYTES);

  copy_state_t             state;
  logic [ADDRESSWIDTH-1:0] src_q;
  logic [ADDRESSWIDTH-1:0] dst_q;
  logic [ADDRESSWIDTH-1:0] len_q;
  logic [ADDRESSWIDTH-1:0] remaining;
  logic [ADDRESSWIDTH-1:0] word_cnt;
  logic                    busy_q;
  logic                    done_q;
  logic                    error_q;
  logic                    go_q;
  logic [1:0]              dwell;
  logic                    xfer;
  logic                    cmd_bad;

  assign xfer = (state == ST_STREAM) && bus.read_user_data_available &&
                !bus.write_user_buffer_full && (remaining != '0);

  assign cmd_bad = (len_q == '0) ||
                   !is_aligned(64'(len_q), LSB) ||
                   !is_aligned(64'(src_q), LSB) ||
                   !is_aligned(64'(dst_q), LSB);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      src_q     <= '0;
      dst_q     <= '0;
      len_q     <= '0;
      remaining <= '0;
      word_cnt  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      go_q      <= 1'b0;
      dwell     <= '0;
    end else begin
      done_q  <= 1'b0;
      error_q <= 1'b0;
      go_q    <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.cmd_start) begin
            src_q    <= bus.cmd_src;
            dst_q    <= bus.cmd_dst;
            len_q    <= bus.cmd_length;
            word_cnt <= '0;
            busy_q   <= 1'b1;
            state    <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (cmd_bad) begin
            // Rejected commands are busy only for the CHECK cycle.
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            error_q <= 1'b1;
            state   <= ST_DONE;
          end else begin
            remaining <= ADDRESSWIDTH'(words_of(64'(len_q), LSB));
            go_q      <= 1'b1;
            state     <= ST_LAUNCH;
          end
        end
        ST_LAUNCH: state <= ST_STREAM;
        ST_STREAM: begin
          if (xfer) begin
            remaining <= remaining - ADDRESSWIDTH'(1);
            word_cnt  <= word_cnt + ADDRESSWIDTH'(1);
            if (remaining == ADDRESSWIDTH'(1)) begin
              dwell <= '0;
              state <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          // Master done flags may still be stale from before launch; let them settle first.
          if (dwell != 2'd2) begin
            dwell <= dwell + 2'd1;
          end else if (bus.read_control_done && bus.write_control_done) begin
            done_q <= 1'b1;
            state  <= ST_DONE;
          end
        end
        ST_DONE: begin
          busy_q <= 1'b0;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.cmd_busy   = busy_q;
  assign bus.cmd_done   = done_q;
  assign bus.cmd_error  = error_q;
  assign bus.word_count = word_cnt;

  assign bus.read_control_fixed_location = 1'b0;
  assign bus.read_control_read_base      = src_q;
  assign bus.read_control_read_length    = len_q;
  assign bus.read_control_go             = go_q;
  assign bus.read_user_read_buffer       = xfer;

  assign bus.write_control_fixed_location = 1'b0;
  assign bus.write_control_write_base     = dst_q;
  assign bus.write_control_write_length   = len_q;
  assign bus.write_control_go             = go_q;
  assign bus.write_user_write_buffer      = xfer;
  assign bus.write_user_buffer_data       = bus.read_user_buffer_output_data;

endmodule
